// File: rtl/weight_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | weight_fetch_ctrl: fetches one channel's BN word and KLEN weight vectors  |
// | from synchronous SRAMs and presents them on a valid/ready stream.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module weight_fetch_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int BN_ADDR_W = 7,
    parameter int BN_W      = 16,
    parameter int LANES     = 8,
    parameter int KLEN      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BN_ADDR_W-1:0] ch_in,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 w_cs,
    output logic                 w_oe,
    output logic                 w_we,
    output logic [ADDR_W-1:0]    w_addr,
    input  logic [LANES-1:0]     w_rdata,
    output logic                 bn_cs,
    output logic                 bn_oe,
    output logic                 bn_we,
    output logic [BN_ADDR_W-1:0] bn_addr,
    input  logic [BN_W-1:0]      bn_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_data,
    output logic                 out_last,
    output logic [BN_W-1:0]      out_bn
);

    localparam int KW = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam int PW = ADDR_W + BN_ADDR_W;
    localparam logic [KW-1:0] K_LAST = KW'(KLEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_BN  = 3'd1,
        S_CAP_BN = 3'd2,
        S_RD_W   = 3'd3,
        S_CAP_W  = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [BN_ADDR_W-1:0]   ch_q, ch_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   done_q, done_d;
    logic                   w_cs_q, w_oe_q, w_cs_d;
    logic                   bn_cs_q, bn_oe_q, bn_cs_d;
    logic [ADDR_W-1:0]      w_addr_q, w_addr_d;
    logic [BN_ADDR_W-1:0]   bn_addr_q, bn_addr_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [LANES-1:0]       out_data_q, out_data_d;
    logic [BN_W-1:0]        out_bn_q, out_bn_d;
    logic                   handshake;

    // Full-width product, then truncated: large channel indices wrap modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] weight_addr(input logic [BN_ADDR_W-1:0] ch,
                                                      input logic [KW-1:0]        k);
        logic [PW-1:0] full;
        full = PW'(ch) * PW'(KLEN) + PW'(k);
        return full[ADDR_W-1:0];
    endfunction

    assign handshake = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        k_d         = k_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_bn_d    = out_bn_q;

        case (state_q)
            S_IDLE: begin
                // The done cycle is still part of the previous request.
                if (start && !done_q) begin
                    state_d = S_RD_BN;
                    ch_d    = ch_in;
                    k_d     = '0;
                end
            end
            S_RD_BN:  state_d = S_CAP_BN;
            S_CAP_BN: begin
                out_bn_d = bn_rdata;
                state_d  = S_RD_W;
            end
            S_RD_W:   state_d = S_CAP_W;
            S_CAP_W: begin
                out_data_d  = w_rdata;
                out_valid_d = 1'b1;
                out_last_d  = (k_q == K_LAST);
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (k_q == K_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = S_RD_W;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            ch_d        = ch_q;
            k_d         = k_q;
            done_d      = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // SRAM controls are registered from the next state so they are high exactly in RD states.
    always_comb begin
        w_cs_d    = (state_d == S_RD_W);
        bn_cs_d   = (state_d == S_RD_BN);
        w_addr_d  = w_addr_q;
        bn_addr_d = bn_addr_q;
        if (state_d == S_RD_W) begin
            w_addr_d = weight_addr(ch_d, k_d);
        end
        if (state_d == S_RD_BN) begin
            bn_addr_d = ch_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            k_q         <= '0;
            done_q      <= 1'b0;
            w_cs_q      <= 1'b0;
            w_oe_q      <= 1'b0;
            bn_cs_q     <= 1'b0;
            bn_oe_q     <= 1'b0;
            w_addr_q    <= '0;
            bn_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_bn_q    <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            k_q         <= k_d;
            done_q      <= done_d;
            w_cs_q      <= w_cs_d;
            w_oe_q      <= w_cs_d;
            bn_cs_q     <= bn_cs_d;
            bn_oe_q     <= bn_cs_d;
            w_addr_q    <= w_addr_d;
            bn_addr_q   <= bn_addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_bn_q    <= out_bn_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign w_cs      = w_cs_q;
    assign w_oe      = w_oe_q;
    assign w_we      = 1'b0;
    assign w_addr    = w_addr_q;
    assign bn_cs     = bn_cs_q;
    assign bn_oe     = bn_oe_q;
    assign bn_we     = 1'b0;
    assign bn_addr   = bn_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_bn    = out_bn_q;

endmodule
`default_nettype wire
